// File: rtl/muldiv_unit_if.sv
// Operation codes from the main decoder and the execute-stage bus of the multiply/divide unit.
// Package and interface share this file so the function type travels with the bus.
package selector;
   typedef enum logic [3:0] {
      MULDIV_NCARE = 4'd0,
      MULDIV_MULT,
      MULDIV_MULTU,
      MULDIV_DIV,
      MULDIV_DIVU,
      MULDIV_MADD,
      MULDIV_MADDU,
      MULDIV_MSUB,
      MULDIV_MSUBU
   } muldiv_function;
endpackage

interface muldiv_unit_if;
   // Handshake: start/func/operands are sampled on a rising edge only while busy=0;
   // busy rises after that edge, and done pulses for one cycle with hi_out/lo_out valid
   // while busy is already low, so a new start may be presented in the done cycle.
   logic                     start;
   selector::muldiv_function func;
   logic                     flush;
   logic [31:0]              rs_value;
   logic [31:0]              rt_value;
   logic [31:0]              hi_in;
   logic [31:0]              lo_in;
   logic                     busy;
   logic                     done;
   logic [31:0]              hi_out;
   logic [31:0]              lo_out;
   logic [1:0]               dbg_state;

   modport master (
      output start, func, flush, rs_value, rt_value, hi_in, lo_in,
      input  busy, done, hi_out, lo_out, dbg_state
   );

   modport slave (
      input  start, func, flush, rs_value, rt_value, hi_in, lo_in,
      output busy, done, hi_out, lo_out, dbg_state
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / restoring-divide unit producing HI/LO.
// Multiplies take two cycles after acceptance, divides thirty-three.
module muldiv_unit #(
   parameter int DIV_ITERS = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_MUL      = 2'd1;
   localparam logic [1:0] S_DIV_ITER = 2'd2;
   localparam logic [1:0] S_DIV_FIX  = 2'd3;

   logic [1:0]               r_state;
   logic                     r_mul_ph;
   logic [4:0]               r_cnt;
   selector::muldiv_function r_func;
   logic [31:0]              r_a;
   logic [31:0]              r_b;
   logic [31:0]              r_rem;
   logic [31:0]              r_quo;
   logic [63:0]              r_acc;
   logic [63:0]              r_prod;
   logic                     r_qsign;
   logic                     r_rsign;
   logic                     r_busy;
   logic                     r_done;
   logic [31:0]              r_hi_out;
   logic [31:0]              r_lo_out;

   logic        w_start_ok;
   logic        w_is_div;
   logic        w_signed_div;
   logic        w_mul_signed;
   logic [63:0] w_ext_a;
   logic [63:0] w_ext_b;
   logic [63:0] w_prod;
   logic [63:0] w_mul_res;
   logic [32:0] w_shift;
   logic [32:0] w_diff;

   always_comb begin
      w_start_ok = 1'b0;
      w_is_div   = 1'b0;
      case (bus.func)
         selector::MULDIV_DIV, selector::MULDIV_DIVU: begin
            w_start_ok = 1'b1;
            w_is_div   = 1'b1;
         end
         selector::MULDIV_MULT, selector::MULDIV_MULTU,
         selector::MULDIV_MADD, selector::MULDIV_MADDU,
         selector::MULDIV_MSUB, selector::MULDIV_MSUBU: w_start_ok = 1'b1;
         default: ;
      endcase
   end

   assign w_signed_div = (bus.func == selector::MULDIV_DIV);
   assign w_mul_signed = (r_func == selector::MULDIV_MULT) || (r_func == selector::MULDIV_MADD) ||
                         (r_func == selector::MULDIV_MSUB);
   assign w_ext_a = w_mul_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
   assign w_ext_b = w_mul_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
   assign w_prod  = w_ext_a * w_ext_b;

   always_comb begin
      w_mul_res = r_prod;
      case (r_func)
         selector::MULDIV_MADD, selector::MULDIV_MADDU: w_mul_res = r_acc + r_prod;
         selector::MULDIV_MSUB, selector::MULDIV_MSUBU: w_mul_res = r_acc - r_prod;
         default: ;
      endcase
   end

   // Restoring step: r_quo starts as the dividend and fills with quotient bits from the right.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_diff  = w_shift - {1'b0, r_b};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_mul_ph <= 1'b0;
         r_cnt    <= 5'd0;
         r_func   <= selector::MULDIV_NCARE;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_acc    <= 64'd0;
         r_prod   <= 64'd0;
         r_qsign  <= 1'b0;
         r_rsign  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi_out <= 32'd0;
         r_lo_out <= 32'd0;
      end else begin
         r_done <= 1'b0;
         if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start && w_start_ok) begin
                     r_func   <= bus.func;
                     r_a      <= bus.rs_value;
                     r_acc    <= {bus.hi_in, bus.lo_in};
                     r_busy   <= 1'b1;
                     r_cnt    <= 5'd0;
                     r_rem    <= 32'd0;
                     r_mul_ph <= 1'b0;
                     r_qsign  <= w_signed_div && (bus.rs_value[31] ^ bus.rt_value[31]);
                     r_rsign  <= w_signed_div && bus.rs_value[31];
                     r_quo    <= (w_signed_div && bus.rs_value[31]) ? -bus.rs_value : bus.rs_value;
                     r_b      <= (w_signed_div && bus.rt_value[31]) ? -bus.rt_value : bus.rt_value;
                     r_state  <= w_is_div ? S_DIV_ITER : S_MUL;
                  end
               end
               S_MUL: begin
                  if (!r_mul_ph) begin
                     r_prod   <= w_prod;
                     r_mul_ph <= 1'b1;
                  end else begin
                     {r_hi_out, r_lo_out} <= w_mul_res;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
               S_DIV_ITER: begin
                  if (!w_diff[32]) begin
                     r_rem <= w_diff[31:0];
                     r_quo <= {r_quo[30:0], 1'b1};
                  end else begin
                     r_rem <= w_shift[31:0];
                     r_quo <= {r_quo[30:0], 1'b0};
                  end
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'(DIV_ITERS - 1)) r_state <= S_DIV_FIX;
               end
               S_DIV_FIX: begin
                  // Zero divisor reports the raw dividend as remainder, never sign-fixed.
                  if (r_b == 32'd0) begin
                     r_lo_out <= 32'hFFFF_FFFF;
                     r_hi_out <= r_a;
                  end else begin
                     r_lo_out <= r_qsign ? -r_quo : r_quo;
                     r_hi_out <= r_rsign ? -r_rem : r_rem;
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.hi_out    = r_hi_out;
   assign bus.lo_out    = r_lo_out;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases pin the reference model, then random traffic
// with flushes is compared every cycle against a latency/arithmetic model of HI/LO.
module tb_muldiv_unit;
   import selector::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   muldiv_unit_if bus ();

   muldiv_unit #(.DIV_ITERS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic chk_en   = 1'b0;

   // Reference model state
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;
   int          m_left = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_result(input muldiv_function f, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
      longint      sp;
      logic [63:0] up;
      logic [63:0] acc;
      int          sa;
      int          sb;
      acc = {h, l};
      sp  = longint'($signed(a)) * longint'($signed(b));
      up  = {32'd0, a} * {32'd0, b};
      sa  = $signed(a);
      sb  = $signed(b);
      case (f)
         MULDIV_MULT:  return 64'(sp);
         MULDIV_MULTU: return up;
         MULDIV_MADD:  return acc + 64'(sp);
         MULDIV_MADDU: return acc + up;
         MULDIV_MSUB:  return acc - 64'(sp);
         MULDIV_MSUBU: return acc - up;
         MULDIV_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         MULDIV_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Model: one op in flight, fixed latency 2 (multiply) or 33 (divide) edges after acceptance.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
            exp_q.delete();
         end else begin
            m_done = 1'b0;
            if (bus.flush) begin
               if (m_busy) void'(exp_q.pop_back());
               m_busy = 1'b0;
            end else if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
                  {m_hi, m_lo} = exp_q.pop_front();
               end
            end else if (bus.start && bus.func != MULDIV_NCARE) begin
               m_busy = 1'b1;
               m_left = (bus.func == MULDIV_DIV || bus.func == MULDIV_DIVU) ? 33 : 2;
               exp_q.push_back(ref_result(bus.func, bus.rs_value, bus.rt_value, bus.hi_in, bus.lo_in));
            end
         end
      end
   end

   // Compare process, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("busy", {63'd0, bus.busy}, {63'd0, m_busy});
            check("done", {63'd0, bus.done}, {63'd0, m_done});
            check("hi_out", {32'd0, bus.hi_out}, {32'd0, m_hi});
            check("lo_out", {32'd0, bus.lo_out}, {32'd0, m_lo});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle();
      for (int k = 0; k < 60 && bus.busy; k++) begin
         @(posedge clk);
         #1;
      end
      if (bus.busy) check("wait_idle timeout", 64'd1, 64'd0);
   endtask

   // Issues one op and counts edges until done; poke>0 pulses a MULT start after that edge.
   task automatic run_op(input string name, input muldiv_function f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_lat,
                         input int poke);
      int lat;
      wait_idle();
      bus.start    = 1'b1;
      bus.func     = f;
      bus.rs_value = a;
      bus.rt_value = b;
      bus.hi_in    = h;
      bus.lo_in    = l;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.func     = MULDIV_NCARE;
      bus.rs_value = $urandom();
      bus.rt_value = $urandom();
      bus.hi_in    = $urandom();
      bus.lo_in    = $urandom();
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         bus.start = (k == poke);
         bus.func  = (k == poke) ? MULDIV_MULT : MULDIV_NCARE;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      bus.start = 1'b0;
      bus.func  = MULDIV_NCARE;
      check({name, " latency"}, 64'(lat), 64'(e_lat));
      check({name, " hi"}, {32'd0, bus.hi_out}, {32'd0, e_hi});
      check({name, " lo"}, {32'd0, bus.lo_out}, {32'd0, e_lo});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 9);
         4:       return 32'hFFFF_FFF0 | $urandom_range(0, 15);
         default: return $urandom();
      endcase
   endfunction

   initial begin
      bus.start    = 1'b0;
      bus.flush    = 1'b0;
      bus.func     = MULDIV_NCARE;
      bus.rs_value = 32'd0;
      bus.rt_value = 32'd0;
      bus.hi_in    = 32'd0;
      bus.lo_in    = 32'd0;
      #1 reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      check("reset busy", {63'd0, bus.busy}, 64'd0);
      check("reset done", {63'd0, bus.done}, 64'd0);
      check("reset hi", {32'd0, bus.hi_out}, 64'd0);
      check("reset lo", {32'd0, bus.lo_out}, 64'd0);

      run_op("MULT",   MULDIV_MULT,   32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
      run_op("MULTU",  MULDIV_MULTU,  32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, 2, 0);
      run_op("MADD",   MULDIV_MADD,   32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2, 0);
      run_op("MSUB",   MULDIV_MSUB,   32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
      run_op("MADDU",  MULDIV_MADDU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFE, 32'h0000_0002, 2, 0);
      run_op("MSUBU",  MULDIV_MSUBU,  32'd3, 32'd4, 32'd0, 32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
      run_op("DIV -7/2", MULDIV_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
      run_op("DIVU 7/2", MULDIV_DIVU, 32'd7, 32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 33, 0);
      run_op("DIV 7/-2", MULDIV_DIV,  32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD, 33, 0);
      run_op("DIVU 5/0", MULDIV_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF, 33, 0);
      run_op("DIV ovf",  MULDIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 33, 0);
      run_op("DIV -5/0", MULDIV_DIV,  32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 0);
      run_op("DIV mid-start", MULDIV_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, 33, 5);

      // Flush at iteration 10 of a divide, then an immediate multiply.
      wait_idle();
      bus.start = 1'b1; bus.func = MULDIV_DIV; bus.rs_value = 32'd1000; bus.rt_value = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.func = MULDIV_NCARE;
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush busy", {63'd0, bus.busy}, 64'd0);
      check("flush done", {63'd0, bus.done}, 64'd0);
      check("flush hi kept", {32'd0, bus.hi_out}, 64'd2);
      check("flush lo kept", {32'd0, bus.lo_out}, 64'd14);
      run_op("MULT after flush", MULDIV_MULT, 32'd5, 32'hFFFF_FFFA, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 2, 0);

      // start together with flush while idle
      bus.start = 1'b1; bus.flush = 1'b1; bus.func = MULDIV_MULT; bus.rs_value = 32'd9; bus.rt_value = 32'd9;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.func = MULDIV_NCARE;
      check("start+flush busy", {63'd0, bus.busy}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("start+flush lo kept", {32'd0, bus.lo_out}, 64'hFFFF_FFE2);

      // NCARE start is ignored
      bus.start = 1'b1; bus.func = MULDIV_NCARE;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("ncare busy", {63'd0, bus.busy}, 64'd0);

      // Randomized traffic with occasional flushes and collisions.
      for (int c = 0; c < 2500; c++) begin
         bus.start    = ($urandom_range(0, 3) == 0);
         bus.func     = muldiv_function'($urandom_range(0, 8));
         bus.rs_value = pick();
         bus.rt_value = pick();
         bus.hi_in    = $urandom();
         bus.lo_in    = $urandom();
         bus.flush    = ($urandom_range(0, 59) == 0);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;

      // Asynchronous reset in the middle of a divide.
      run_op("MULT pre-reset", MULDIV_MULT, 32'h1234, 32'h10, 32'd0, 32'd0, 32'd0, 32'h0001_2340, 2, 0);
      bus.start = 1'b1; bus.func = MULDIV_DIVU; bus.rs_value = 32'd77; bus.rt_value = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.func = MULDIV_NCARE;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async reset busy", {63'd0, bus.busy}, 64'd0);
      check("async reset done", {63'd0, bus.done}, 64'd0);
      check("async reset hi", {32'd0, bus.hi_out}, 64'd0);
      check("async reset lo", {32'd0, bus.lo_out}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run_op("MULT 3x4", MULDIV_MULT, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd12, 2, 0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
